uart_word_tx: RTL and testbench



---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_word_fifo.sv | 85 ++++++++
 rtl/uart_word_tx.sv | 158 +++++++++++++++
 tb/tb_uart_word_tx.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the word-oriented UART transmitter.
// Contents: default bit-time length, frame geometry, serializer state
// encoding and the helper that maps a serializer state to a line level.
package uart_pkg;

    // Clock cycles per bit time: 200 gives 0.5 MBd from a 100 MHz clock.
    localparam int SERIAL_WCNT         = 200;
    // Start bit + 8 data bits + 1 stop bit.
    localparam int UART_BITS_PER_FRAME = 10;
    localparam int UART_DATA_BITS      = 8;
    localparam int UART_BYTES_PER_WORD = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    // Line level for a given serializer state; the line idles high.
    function automatic logic line_level(input tx_state_e st, input logic data_bit);
        logic lvl;
        case (st)
            ST_START: lvl = 1'b0;
            ST_DATA:  lvl = data_bit;
            default:  lvl = 1'b1;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/uart_word_fifo.sv
// Synchronous word FIFO feeding the UART serializer.
// Ports:
//   clk, i_rst          clock and synchronous active-high reset
//   i_push, i_data      write request and word (ignored while full)
//   i_pop               read request (ignored while empty)
//   o_head              word at the read pointer
//   o_count             occupancy, 0..DEPTH
//   o_full, o_empty     occupancy flags, derived from registers only
module uart_word_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    // Full refuses a push even when a pop happens on the same edge.
    assign push_ok = i_push && !o_full;
    assign pop_ok  = i_pop && !o_empty;

    assign o_full  = (count_q == CNT_W'(DEPTH));
    assign o_empty = (count_q == CNT_W'(0));
    assign o_count = count_q;
    assign o_head  = mem_q[rd_ptr_q];

    // Next pointer and occupancy values; pointers wrap modulo DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; reset discards all queued words.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            wr_ptr_q <= PTR_W'(0);
            rd_ptr_q <= PTR_W'(0);
            count_q  <= CNT_W'(0);
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

endmodule

// File: rtl/uart_word_tx.sv
// Buffered UART transmitter: queues 32-bit words and sends each as four
// 8N1 frames, least-significant byte first, each bit lasting WAIT_CNT clks.
// Ports:
//   clk, i_rst          clock and synchronous active-high reset
//   i_data, i_valid     word source; a push happens when i_valid && o_ready
//   o_ready             FIFO not full (register-derived)
//   o_txd               serial line, idles high
//   o_busy              low only when idle with an empty FIFO (registered)
//   o_count             FIFO occupancy
module uart_word_tx
    import uart_pkg::*;
#(
    parameter int WAIT_CNT   = SERIAL_WCNT,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        i_rst,
    input  logic [31:0]                 i_data,
    input  logic                        i_valid,
    output logic                        o_ready,
    output logic                        o_txd,
    output logic                        o_busy,
    output logic [$clog2(FIFO_DEPTH):0] o_count
);

    localparam int WCNT_W = $clog2(WAIT_CNT + 1);

    tx_state_e         state_q, state_d;
    logic [31:0]       shreg_q, shreg_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [WCNT_W-1:0] wait_q, wait_d;
    logic              txd_q, txd_d;
    logic              busy_q, busy_d;

    logic              fifo_pop;
    logic [31:0]       fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              bit_done;

    uart_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk     (clk),
        .i_rst   (i_rst),
        .i_push  (i_valid),
        .i_data  (i_data),
        .i_pop   (fifo_pop),
        .o_head  (fifo_head),
        .o_count (o_count),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    assign o_ready  = !fifo_full;
    assign o_txd    = txd_q;
    assign o_busy   = busy_q;
    // The counter runs 1..WAIT_CNT inside every bit time.
    assign bit_done = (wait_q == WCNT_W'(WAIT_CNT));

    // Serializer next state, byte sequencing and FIFO pop.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        wait_d     = wait_q;
        fifo_pop   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    shreg_d    = fifo_head;
                    byte_idx_d = 2'd0;
                    bit_idx_d  = 3'd0;
                    wait_d     = WCNT_W'(1);
                    state_d    = ST_START;
                end else begin
                    wait_d = WCNT_W'(0);
                end
            end
            ST_START: begin
                if (bit_done) begin
                    wait_d    = WCNT_W'(1);
                    bit_idx_d = 3'd0;
                    state_d   = ST_DATA;
                end else begin
                    wait_d = wait_q + WCNT_W'(1);
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    wait_d  = WCNT_W'(1);
                    // Shifting the whole word leaves the next byte in [7:0].
                    shreg_d = {1'b0, shreg_q[31:1]};
                    if (bit_idx_q == 3'(UART_DATA_BITS - 1)) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    wait_d = wait_q + WCNT_W'(1);
                end
            end
            ST_STOP: begin
                if (bit_done) begin
                    wait_d = WCNT_W'(1);
                    if (byte_idx_q != 2'(UART_BYTES_PER_WORD - 1)) begin
                        byte_idx_d = byte_idx_q + 2'd1;
                        state_d    = ST_START;
                    end else if (!fifo_empty) begin
                        // Pop on the last stop cycle so the next start bit follows directly.
                        fifo_pop   = 1'b1;
                        shreg_d    = fifo_head;
                        byte_idx_d = 2'd0;
                        state_d    = ST_START;
                    end else begin
                        wait_d  = WCNT_W'(0);
                        state_d = ST_IDLE;
                    end
                end else begin
                    wait_d = wait_q + WCNT_W'(1);
                end
            end
            default: begin
                wait_d  = WCNT_W'(0);
                state_d = ST_IDLE;
            end
        endcase
        // The line lags the state by one cycle, hence start bit at t+2 after a push at t.
        txd_d  = line_level(state_q, shreg_q[0]);
        busy_d = !((state_q == ST_IDLE) && fifo_empty);
    end

    // Serializer registers; reset aborts any frame in progress.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            shreg_q    <= 32'd0;
            bit_idx_q  <= 3'd0;
            byte_idx_q <= 2'd0;
            wait_q     <= WCNT_W'(0);
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            wait_q     <= wait_d;
            txd_q      <= txd_d;
            busy_q     <= busy_d;
        end
    end

endmodule

// File: tb/tb_uart_word_tx.sv
// Self-checking bench for uart_word_tx (WAIT_CNT=4, FIFO_DEPTH=4).
// A line receiver decodes o_txd into bytes; accepted words are expanded
// into an expected byte stream and the two are compared in order.
module tb_uart_word_tx;

    localparam int W     = 4;
    localparam int D     = 4;
    localparam int FRAME = 10 * W;

    logic        clk = 1'b0;
    logic        i_rst;
    logic [31:0] i_data;
    logic        i_valid;
    logic        o_ready;
    logic        o_txd;
    logic        o_busy;
    logic [2:0]  o_count;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    int         st_q[$];

    uart_word_tx #(.WAIT_CNT(W), .FIFO_DEPTH(D)) dut (
        .clk     (clk),
        .i_rst   (i_rst),
        .i_data  (i_data),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_txd   (o_txd),
        .o_busy  (o_busy),
        .o_count (o_count)
    );

    always #5 clk = ~clk;

    // Edge counter: after edge n (sampled #1 later) cyc == n.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Line receiver: detects a start bit, samples mid-bit, records frame start cycles.
    initial begin : rx_model
        int         cnt;
        logic       act;
        logic [7:0] b;
        act = 1'b0;
        cnt = 0;
        b   = 8'd0;
        forever begin
            @(negedge clk);
            if (i_rst === 1'b1) begin
                act = 1'b0;
            end else if (!act) begin
                if (o_txd === 1'b0) begin
                    act = 1'b1;
                    cnt = 0;
                    st_q.push_back(cyc);
                end
            end else begin
                cnt++;
                if (cnt == W / 2) check("start_bit", 32'(o_txd), 32'd0);
                if ((cnt % W) == (W / 2) && (cnt / W) >= 1 && (cnt / W) <= 8)
                    b[cnt / W - 1] = o_txd;
                if (cnt == 9 * W + W / 2) begin
                    check("stop_bit", 32'(o_txd), 32'd1);
                    rx_q.push_back(b);
                end
                if (cnt == FRAME - 1) act = 1'b0;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Offers a word until accepted; acc is the accepting edge.
    task automatic push_word(input logic [31:0] w, output int acc);
        logic r;
        int   guard;
        i_data  = w;
        i_valid = 1'b1;
        acc     = -1;
        guard   = 0;
        while (acc < 0 && guard < 3000) begin
            r = o_ready;
            @(posedge clk);
            #1;
            guard++;
            if (r) begin
                acc = cyc;
                for (int k = 0; k < 4; k++) exp_q.push_back(w[8*k +: 8]);
            end
        end
        check("push_accepted", 32'(acc >= 0), 32'd1);
    endtask

    // Waits for o_busy to drop; fall is the edge where it was first seen low.
    task automatic wait_idle(output int fall);
        int guard;
        guard   = 0;
        i_valid = 1'b0;
        step(2);
        while (o_busy !== 1'b0 && guard < 5000) begin
            step(1);
            guard++;
        end
        check("went_idle", 32'(o_busy), 32'd0);
        fall = cyc;
    endtask

    task automatic check_stream(input string tag, input bit contig);
        check({tag, "_len"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (i < rx_q.size()) check({tag, "_byte"}, 32'(rx_q[i]), 32'(exp_q[i]));
        if (contig)
            for (int i = 1; i < st_q.size(); i++)
                check({tag, "_gap"}, st_q[i] - st_q[i-1], FRAME);
        exp_q.delete();
        rx_q.delete();
        st_q.delete();
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL global_timeout: got no finish, expected finish before 100000 cycles");
        $fatal(1);
    end

    initial begin : main
        int t, t2, tc, f, lows, n, gap;
        int acc [1:7];

        i_rst   = 1'b1;
        i_valid = 1'b0;
        i_data  = 32'd0;

        // Reset
        step(3);
        check("rst_txd", 32'(o_txd), 32'd1);
        check("rst_ready", 32'(o_ready), 32'd1);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_count", 32'(o_count), 32'd0);
        i_rst = 1'b0;
        lows  = 0;
        for (int i = 0; i < 1000; i++) begin
            step(1);
            if (o_txd !== 1'b1) lows++;
        end
        check("idle_line_low_cycles", lows, 0);
        check("idle_busy", 32'(o_busy), 32'd0);

        // Single word
        push_word(32'h12345678, t);
        i_valid = 1'b0;
        step(1);
        check("txd_t1", 32'(o_txd), 32'd1);
        step(1);
        check("start_t2", 32'(o_txd), 32'd0);
        check("busy_t2", 32'(o_busy), 32'd1);
        wait_idle(f);
        check("busy_fall", f - t, 162);
        check("frames_single", st_q.size(), 4);
        if (st_q.size() == 4) begin
            check("first_start", st_q[0] - t, 2);
            check("activity", st_q[3] - st_q[0] + FRAME, 160);
        end
        check_stream("single", 1'b1);

        // Contiguity
        push_word(32'hA5A5A5A5, t);
        push_word(32'h00FF00FF, t2);
        check("back_to_back", t2 - t, 1);
        wait_idle(f);
        check("frames_contig", st_q.size(), 8);
        if (st_q.size() == 8) check("span_contig", st_q[7] - st_q[0] + FRAME, 320);
        check_stream("contig", 1'b1);

        // Full FIFO
        for (int w = 1; w <= 7; w++) begin
            push_word(32'(w), acc[w]);
            if (w == 5) begin
                check("count_full", 32'(o_count), 32'd4);
                check("ready_full", 32'(o_ready), 32'd0);
            end
        end
        i_valid = 1'b0;
        check("acc_w2", acc[2] - acc[1], 1);
        check("acc_w5", acc[5] - acc[1], 4);
        check("acc_w6", acc[6] - acc[1], 162);
        check("acc_w7", acc[7] - acc[1], 322);
        wait_idle(f);
        check_stream("full", 1'b1);

        // Same-edge push and pop
        push_word($urandom, t);
        push_word($urandom, t2);
        i_valid = 1'b0;
        step((t + 160) - cyc);
        check("one_queued", 32'(o_count), 32'd1);
        push_word($urandom, tc);
        i_valid = 1'b0;
        check("push_on_pop_edge", tc - t, 161);
        check("count_same_edge", 32'(o_count), 32'd1);
        wait_idle(f);
        check_stream("same_edge", 1'b1);

        // Mid-frame reset during data bit 3 of byte 1
        push_word(32'h00000000, t);
        push_word($urandom, t2);
        push_word($urandom, tc);
        i_valid = 1'b0;
        check("two_queued", 32'(o_count), 32'd2);
        step((t + 59) - cyc);
        check("mid_frame_low", 32'(o_txd), 32'd0);
        i_rst = 1'b1;
        step(1);
        check("abort_txd", 32'(o_txd), 32'd1);
        check("abort_count", 32'(o_count), 32'd0);
        check("abort_busy", 32'(o_busy), 32'd0);
        check("abort_ready", 32'(o_ready), 32'd1);
        step(2);
        i_rst = 1'b0;
        exp_q.delete();
        rx_q.delete();
        st_q.delete();
        step(1);
        push_word(32'h000000C3, t);
        wait_idle(f);
        check("after_rst_frames", st_q.size(), 4);
        check_stream("after_rst", 1'b1);

        // Randomized bursts with random gaps
        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(2, 8);
            for (int i = 0; i < n; i++) begin
                push_word($urandom, t);
                gap = $urandom_range(0, 3);
                if (gap > 0) begin
                    i_valid = 1'b0;
                    step(gap);
                end
            end
            wait_idle(f);
            check_stream("rand", 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
